// File: rtl/recip_arbiter.sv
// Round-robin arbiter sharing one reciprocal engine among N requesters, with a watchdog abort.
// Latency: grant to rsp_valid_o = engine latency + 2; a held response blocks every further grant.
module recip_arbiter #(
    parameter int W       = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N*W-1:0]       req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [$clog2(N)-1:0] rsp_id_o,
    output logic [W-1:0]         rsp_data_o,
    output logic                 rsp_invalid_o,
    output logic                 rsp_timeout_o,
    output logic                 eng_start_o,
    output logic [W-1:0]         eng_x_o,
    output logic                 eng_rst_n_o,
    input  logic                 eng_done_i,
    input  logic [W-1:0]         eng_result_i,
    input  logic                 eng_invalid_i,
    output logic                 busy_o
);

    localparam int IDW = $clog2(N);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [W-1:0]   eng_x_q, eng_x_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_invalid_q, rsp_invalid_d;
    logic           rsp_timeout_q, rsp_timeout_d;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   grant_oh;
    logic           grant_vld;
    logic [IDW-1:0] grant_off;
    logic [IDW:0]   grant_sum;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   grant_dat;
    logic [IDW:0]   rr_inc;

    // Rotate requests so bit k is requester (rr_ptr + k) mod N; lowest set bit wins.
    always_comb begin
        req_dbl   = {req_valid_i, req_valid_i} >> rr_ptr_q;
        req_rot   = req_dbl[N-1:0];
        grant_vld = |req_rot;
        grant_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) grant_off = IDW'(k);
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        if (grant_sum >= (IDW+1)'(N)) grant_sum = grant_sum - (IDW+1)'(N);
        grant_id  = grant_sum[IDW-1:0];
        grant_oh  = '0;
        grant_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_id == IDW'(k)) begin
                grant_oh[k] = 1'b1;
                grant_dat   = req_data_i[k*W +: W];
            end
        end
        rr_inc = {1'b0, rsp_id_q} + (IDW+1)'(1);
        if (rr_inc >= (IDW+1)'(N)) rr_inc = '0;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        eng_x_d       = eng_x_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_invalid_d = rsp_invalid_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready_o   = '0;
        eng_start_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld && !rst_i) begin
                    req_ready_o = grant_oh;
                    eng_x_d     = grant_dat;
                    rsp_id_d    = grant_id;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start_o = 1'b1;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A done arriving on the last allowed cycle still counts as a completion.
                if (eng_done_i) begin
                    rsp_data_d    = eng_invalid_i ? '0 : eng_result_i;
                    rsp_invalid_d = eng_invalid_i;
                    state_d       = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_ABORT;
                end
            end
            S_ABORT: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_invalid_d = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rr_ptr_d      = rr_inc[IDW-1:0];
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            eng_x_q       <= '0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_invalid_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            eng_x_q       <= eng_x_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_invalid_q <= rsp_invalid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_id_o      = rsp_id_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_invalid_o = rsp_invalid_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign eng_x_o       = eng_x_q;
    assign eng_rst_n_o   = !rst_i && (state_q != S_ABORT);
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_recip_arbiter.sv
// Bench for recip_arbiter: vector table, hand sequences and random traffic against a reference model.
// Includes a behavioural reciprocal engine with programmable latency.
module tb_recip_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_invalid, rsp_timeout, eng_start, eng_rst_n, busy;
    logic [W-1:0]   eng_x;
    logic           eng_done;
    logic [W-1:0]   eng_result = '0;
    logic           eng_invalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int mrr = 0;

    always #5 clk = ~clk;

    recip_arbiter #(.W(W), .N(N), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_invalid_o(rsp_invalid), .rsp_timeout_o(rsp_timeout),
        .eng_start_o(eng_start), .eng_x_o(eng_x), .eng_rst_n_o(eng_rst_n),
        .eng_done_i(eng_done), .eng_result_i(eng_result), .eng_invalid_i(eng_invalid),
        .busy_o(busy)
    );

    function automatic logic [W-1:0] ref_recip(input logic [W-1:0] x);
        logic [63:0] q;
        if ($signed(x) <= 0) return '0;
        q = 64'h1_0000_0000 / {32'd0, x};
        return q[W-1:0];
    endfunction

    // Engine model: done pulses lat cycles after the edge that sees eng_start.
    int          eng_lat = 1;
    int          cnt = 0;
    logic        act = 1'b0;
    logic        stub_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [W-1:0] opnd = '0;
    assign eng_done = stub_done | spur_done;

    always @(posedge clk) begin
        if (!eng_rst_n) begin
            act       <= 1'b0;
            stub_done <= 1'b0;
            cnt       <= 0;
        end else begin
            stub_done <= 1'b0;
            if (eng_start) begin
                act  <= 1'b1;
                cnt  <= eng_lat;
                opnd <= eng_x;
            end else if (act) begin
                if (cnt <= 1) begin
                    act         <= 1'b0;
                    stub_done   <= 1'b1;
                    eng_result  <= ref_recip(opnd);
                    eng_invalid <= ($signed(opnd) <= 0);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(mrr + k) % N]) return (mrr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] lane(input int id, input logic [W-1:0] x);
        logic [N*W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) if (i == id) d[i*W +: W] = x;
        return d;
    endfunction

    // One full transaction, checked against the model; returns the observed response.
    task automatic do_txn(input logic [N-1:0] mask, input logic [N*W-1:0] data, input int lat,
                          input int rdy_dly, output int gid, output logic [W-1:0] rd,
                          output logic rinv, output logic rto);
        int exp_g, n, n_rsp, n_to, rst_lo;
        logic [W-1:0] exp_x, exp_d;
        logic got, x_ok, start_ok, stable_ok, noreq_ok, exp_to, exp_inv;
        exp_g = model_pick(mask);
        exp_x = data[exp_g*W +: W];
        exp_to = (lat > TO - 1);
        exp_inv = !exp_to && ($signed(exp_x) <= 0);
        exp_d = exp_to ? '0 : ref_recip(exp_x);
        eng_lat = lat; req_valid = mask; req_data = data;
        got = 1'b0; gid = -1; rd = '0; rinv = 1'b0; rto = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (req_ready != '0) got = 1'b1;
            else @(negedge clk);
        end
        check("grant_seen", 64'(got), 64'd1);
        if (!got) begin req_valid = '0; return; end
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        check("grant_onehot", 64'(req_ready), 64'd1 << exp_g);
        @(negedge clk);
        req_valid = '0;
        check("issue_start", 64'(eng_start), 64'd1);
        check("issue_x", 64'(eng_x), 64'(exp_x));
        n = 0; n_rsp = 0; n_to = 0; rst_lo = 0; x_ok = 1'b1; start_ok = 1'b1;
        while (n_rsp == 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (eng_start) start_ok = 1'b0;
            if (!eng_rst_n) rst_lo++;
            if (rsp_timeout && n_to == 0) n_to = n;
            if (eng_x !== exp_x) x_ok = 1'b0;
            if (rsp_valid) n_rsp = n;
        end
        check("rsp_seen", 64'(n_rsp != 0), 64'd1);
        check("single_start", 64'(start_ok), 64'd1);
        check("x_stable", 64'(x_ok), 64'd1);
        if (exp_to) begin
            // 16 WAIT cycles after the eng_start cycle, flag visible in the following (ABORT) cycle.
            check("timeout_cycle", 64'(n_to), 64'(TO + 1));
            check("eng_rst_low_cycles", 64'(rst_lo), 64'd1);
            check("timeout_rsp_cycle", 64'(n_rsp), 64'(TO + 2));
        end else begin
            // Engine latency (start cycle to done cycle) is lat+1; response lat+2 cycles after start.
            check("rsp_latency", 64'(n_rsp), 64'(lat + 2));
            check("eng_rst_high", 64'(rst_lo), 64'd0);
        end
        rd = rsp_data; rinv = rsp_invalid; rto = rsp_timeout;
        check("rsp_id", 64'(rsp_id), 64'(exp_g));
        check("rsp_data", 64'(rsp_data), 64'(exp_d));
        check("rsp_invalid", 64'(rsp_invalid), 64'(exp_inv));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        stable_ok = 1'b1; noreq_ok = 1'b1;
        for (int c = 0; c < rdy_dly; c++) begin
            req_valid = '1;
            #1;
            if (req_ready != '0) noreq_ok = 1'b0;
            if (!rsp_valid || rsp_data !== rd || rsp_invalid !== rinv ||
                rsp_timeout !== rto || rsp_id !== 2'(exp_g)) stable_ok = 1'b0;
            @(negedge clk);
        end
        if (rdy_dly > 0) begin
            check("bp_stable", 64'(stable_ok), 64'd1);
            check("bp_no_grant", 64'(noreq_ok), 64'd1);
        end
        rsp_ready = 1'b1; req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("accept_valid_low", 64'(rsp_valid), 64'd0);
        check("accept_flags_clear", 64'({rsp_invalid, rsp_timeout, busy}), 64'd0);
        mrr = (exp_g + 1) % N;
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [W-1:0] x;
        int           lat;
        int           rdy;
        int           exp_id;
        logic [W-1:0] exp_data;
        logic         exp_inv;
        logic         exp_to;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int g, sg;
        logic [W-1:0] d;
        logic inv, to, stray;
        int fair_exp[8];
        logic [N*W-1:0] rdat;
        logic [N-1:0] rmask;

        tbl[0] = '{4'b0010, 32'h0002_0000,    3, 0, 1, 32'h0000_8000, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 32'hFFFF_0000,    2, 0, 0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 32'h0000_0000,    1, 0, 2, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 32'h0001_0000,   15, 0, 3, 32'h0001_0000, 1'b0, 1'b0};
        tbl[4] = '{4'b0001, 32'h0004_0000, 1000, 0, 0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[5] = '{4'b0100, 32'h0000_8000,    5, 5, 2, 32'h0002_0000, 1'b0, 1'b0};
        tbl[6] = '{4'b0010, 32'h7FFF_FFFF,    1, 2, 1, 32'h0000_0002, 1'b0, 1'b0};
        fair_exp = '{0, 2, 0, 2, 3, 0, 2, 3};

        req_valid = '1;
        repeat (3) @(negedge clk);
        check("rst_eng_rst_n", 64'(eng_rst_n), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_no_grant", 64'(req_ready), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("post_rst_eng_rst_n", 64'(eng_rst_n), 64'd1);
        check("post_rst_outputs", 64'({rsp_valid, rsp_id, rsp_invalid, rsp_timeout, eng_start}), 64'd0);
        check("post_rst_data", 64'({rsp_data, eng_x}), 64'd0);
        @(negedge clk);

        // Round-robin between 0 and 2, then requester 3 joins.
        for (int i = 0; i < 8; i++) begin
            do_txn(i < 4 ? 4'b0101 : 4'b1101, {4{32'h0001_0000}}, 2, 0, g, d, inv, to);
            check($sformatf("fair_order[%0d]", i), 64'(g), 64'(fair_exp[i]));
        end

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].mask, lane(tbl[i].exp_id, tbl[i].x), tbl[i].lat, tbl[i].rdy, g, d, inv, to);
            check($sformatf("tbl%0d_id", i), 64'(g), 64'(tbl[i].exp_id));
            check($sformatf("tbl%0d_data", i), 64'(d), 64'(tbl[i].exp_data));
            check($sformatf("tbl%0d_flags", i), 64'({inv, to}), 64'({tbl[i].exp_inv, tbl[i].exp_to}));
        end

        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("spurious_done_ignored", 64'({busy, rsp_valid}), 64'd0);

        // Leave rr pointer at 3, then reset mid-WAIT and confirm it returns to 0.
        do_txn(4'b0100, lane(2, 32'h0002_0000), 2, 0, g, d, inv, to);
        eng_lat = 10; req_valid = 4'b0010; req_data = lane(1, 32'h0002_0000);
        #1;
        check("rstwait_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait_eng_rst_n", 64'(eng_rst_n), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwait_idle", 64'({busy, rsp_valid}), 64'd0);
        mrr = 0;
        stray = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) stray = 1'b1;
        end
        check("rstwait_no_stale_rsp", 64'(stray), 64'd0);
        do_txn(4'b1010, {32'h0002_0000, 32'h0, 32'h0004_0000, 32'h0}, 2, 0, g, d, inv, to);
        check("rstwait_rr_zero", 64'(g), 64'd1);

        for (int t = 0; t < 40; t++) begin
            rmask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0: rdat[i*W +: W] = '0;
                    1: rdat[i*W +: W] = $urandom | 32'h8000_0000;
                    default: rdat[i*W +: W] = $urandom_range(2, 32'h7FFF_FFFF);
                endcase
            end
            sg = model_pick(rmask);
            do_txn(rmask, rdat, $urandom_range(1, 18), $urandom_range(0, 3), g, d, inv, to);
            check("rand_grant", 64'(g), 64'(sg));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
